shift_rows_pipe: RTL and testbench
==================================

// Module: shift_rows_pipe
// PURPOSE
//  Registered, parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
//  Supports state widths of 4, 6 or 8 columns and selects the direction per transfer.
//  Has a valid/ready handshake and a 2-entry output buffer, so it can sit between round
//  stages and a stalling consumer without losing throughput.
//  Replaces the fixed 128-bit combinational inverse shift with one block usable in both
//  encrypt and decrypt pipes.
// PARAMETERS
//  NB     4  state columns; legal values 4, 6, 8; any other value is an elaboration error
//  TAG_W  4  width of the sideband tag carried alongside each state (>=1)
// PORTS
//  clk        in   1         clock; all logic is on the rising edge
//  rst_n      in   1         synchronous reset, active-low
//  in_valid   in   1         in_data, in_inv and in_tag are valid
//  in_ready   out  1         block can accept a state this cycle
//  in_data    in   32*NB     state, column-major
//  in_inv     in   1         0 = ShiftRows, 1 = InvShiftRows; sampled with the data
//  in_tag     in   TAG_W     sideband, passed through unchanged
//  out_valid  out  1         out_data and out_tag hold a result
//  out_ready  in   1         consumer accepts the result
//  out_data   out  32*NB     permuted state
//  out_tag    out  TAG_W     tag of the state on out_data
//  occupancy  out  2         number of buffered entries (0..2)
// BEHAVIOUR
//  Byte layout:
//   - W = 32*NB; byte(r,c) = data[W-1-8*(4c+r) -: 8]; r = row 0..3, c = column 0..NB-1.
//   - Column 0 occupies the MSBs.
//  Shift offsets s(r):
//   - NB=4: 0,1,2,3.  NB=6: 0,1,2,3.  NB=8: 0,1,3,4.
//  Permutation:
//   - Forward: out(r,c) = in(r, (c+s(r)) mod NB).
//   - Inverse: out(r,c) = in(r, (c-s(r)) mod NB).
//   - Applied combinationally on the input side; the buffer stores results already permuted.
//   - Applying forward then inverse (or inverse then forward) returns the original state.
//  Handshake:
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_data, in_inv and in_tag must be held stable while in_valid is high and in_ready is low.
//  Storage:
//   - 2-entry FIFO (head and tail registers plus a count).
//   - Results leave in acceptance order.
//   - The tag always stays paired with its own data.
//  Ready and valid:
//   - in_ready = rst_n & (occupancy != 2). Driven from registered state only; there is no
//     combinational path from out_ready.
//   - out_valid = (occupancy != 0). out_data and out_tag show the head entry.
//  Latency:
//   - A state pushed at edge k is on out_data with out_valid=1 in cycle k+1 when the buffer
//     was empty.
//  Throughput:
//   - One state per cycle when out_ready is held high (occupancy stays at 1).
//  Occupancy update:
//   - push only: +1.  pop only: -1.  push and pop together: unchanged; the head advances and
//     the new entry is written behind it.
//   - occupancy=2: in_ready=0, so no push occurs even if pop=1 that cycle. in_ready rises the
//     next cycle.
//   - occupancy=0: out_valid=0. out_ready is ignored and out_data holds its last value.
//  Holding:
//   - out_data and out_tag stay stable while out_valid=1 and out_ready=0.
//  Reset (rst_n=0 at an edge):
//   - occupancy=0, out_valid=0, out_data=0, out_tag=0, pointers=0.
//   - in_ready=0 while rst_n is low.
//   - Takes effect mid-transfer: buffered entries are discarded and a push in that cycle is
//     ignored.
//  Mode changes:
//   - in_inv may change on every transfer; mixed-direction streams are legal.
// TESTING
//  1. NB=4, forward, in=000102030405060708090a0b0c0d0e0f, out_ready=1
//     -> out=00050a0f04090e03080d02070c01060b one cycle later.
//  2. NB=4, inverse, same input -> out=000d0a0704010e0b0805020f0c090603.
//     Then feed that output forward -> the original input returns.
//  3. NB=8, byte(r,c)=4c+r, forward -> out(2,0)=0e, out(3,0)=13, out(1,7)=01, out(0,5)=14.
//     Inverse of that result restores the input.
//  4. out_ready=0, push 3 states with tags 1,2,3 -> occupancy 1,2,2 and in_ready=0 after the
//     2nd push. Then out_ready=1 -> tags come out 1,2,3 in order with data unchanged.
//  5. Back-to-back stream of 16 states with alternating in_inv and out_ready=1
//     -> one output per cycle, occupancy==1 throughout, every result correct.
//  6. rst_n=0 for one cycle while occupancy=2
//     -> next cycle occupancy=0, out_valid=0, out_data=0, and in_ready=1 once rst_n=1.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// ----------------------------------------------------------------------------
// shift_rows_pipe
//
// Registered ShiftRows / InvShiftRows stage for an AES/Rijndael datapath with
// 4, 6 or 8 state columns. The row rotation is applied combinationally on the
// input side, and each result is stored in a 2-entry output buffer. The
// valid/ready handshake keeps the stage at full throughput in front of a
// consumer that may stall.
//
// Byte layout: byte(r,c) = data[W-1-8*(4c+r) -: 8], so column 0 sits in the
// MSBs. Row r is rotated by s(r) columns: left for forward, right for inverse.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous reset, active-low
//   in_valid   in   1         in_data / in_inv / in_tag are valid
//   in_ready   out  1         a state can be accepted this cycle
//   in_data    in   32*NB     state, column-major
//   in_inv     in   1         0 = ShiftRows, 1 = InvShiftRows
//   in_tag     in   TAG_W     sideband, carried unchanged with the state
//   out_valid  out  1         out_data / out_tag hold a result
//   out_ready  in   1         consumer takes the result
//   out_data   out  32*NB     permuted state (head of the buffer)
//   out_tag    out  TAG_W     tag belonging to out_data
//   occupancy  out  2         buffered entries, 0..2
// ----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy
);

    localparam int W = 32 * NB;

    // Buffer fill levels. The count doubles as the controller state.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("shift_rows_pipe: TAG_W must be at least 1");
        end
    endgenerate

    // Rotation amount of each row. The 8-column state uses the wider
    // Rijndael offsets for rows 2 and 3.
    function automatic int row_shift(input int row);
        case (row)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Permutation network
    // Both directions are plain wiring. Only the final select depends on
    // in_inv, so the direction can change on every transfer.
    // ------------------------------------------------------------------------
    logic [W-1:0] fwd_data;
    logic [W-1:0] inv_data;
    logic [W-1:0] perm_data;

    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < NB; c++) begin : g_col
                localparam int FWD_SRC = (c + row_shift(r)) % NB;
                localparam int INV_SRC = (c + NB - row_shift(r)) % NB;
                localparam int DST_HI  = W - 1 - 8 * (4 * c + r);
                localparam int FWD_HI  = W - 1 - 8 * (4 * FWD_SRC + r);
                localparam int INV_HI  = W - 1 - 8 * (4 * INV_SRC + r);

                assign fwd_data[DST_HI -: 8] = in_data[FWD_HI -: 8];
                assign inv_data[DST_HI -: 8] = in_data[INV_HI -: 8];
            end
        end
    endgenerate

    assign perm_data = in_inv ? inv_data : fwd_data;

    // ------------------------------------------------------------------------
    // Handshake
    // in_ready depends only on the registered count and on reset. There is no
    // path from out_ready, so a full buffer rejects a push even in a cycle
    // where it also pops.
    // ------------------------------------------------------------------------
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = rst_n & (count != OCC_FULL);
    assign out_valid = (count != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = count;

    // ------------------------------------------------------------------------
    // Two-entry buffer
    // The head register drives the outputs directly. The tail register holds
    // the second entry while the consumer stalls. When the last entry is
    // popped, the head is left untouched, so out_data keeps its last value
    // while the buffer is empty.
    // ------------------------------------------------------------------------
    logic [W-1:0]     head_data;
    logic [TAG_W-1:0] head_tag;
    logic [W-1:0]     tail_data;
    logic [TAG_W-1:0] tail_tag;

    // NOTE: the data registers are reset along with the count because out_data
    // and out_tag must read zero after reset, not stale contents. All state
    // updates use non-blocking assignments, so every branch sees the
    // pre-edge count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= OCC_EMPTY;
            head_data <= '0;
            head_tag  <= '0;
            tail_data <= '0;
            tail_tag  <= '0;
        end else begin
            case (count)
                OCC_EMPTY: begin
                    if (push) begin
                        head_data <= perm_data;
                        head_tag  <= in_tag;
                        count     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        // Streaming case: the head retires and the new result
                        // replaces it in the same cycle.
                        head_data <= perm_data;
                        head_tag  <= in_tag;
                    end else if (push) begin
                        tail_data <= perm_data;
                        tail_tag  <= in_tag;
                        count     <= OCC_FULL;
                    end else if (pop) begin
                        count     <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // No push is possible here because in_ready is low.
                    if (pop) begin
                        head_data <= tail_data;
                        head_tag  <= tail_tag;
                        count     <= OCC_ONE;
                    end
                end
                default: begin
                    count <= OCC_EMPTY;
                end
            endcase
        end
    end

    assign out_data = head_data;
    assign out_tag  = head_tag;

    // ------------------------------------------------------------------------
    // Properties
    // ------------------------------------------------------------------------
    a_occ_range: assert property (@(posedge clk) count != 2'd3);

    a_out_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_tag))
    );

    a_no_push_when_full: assert property (
        @(posedge clk) (count == OCC_FULL) |-> !in_ready
    );

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Two instances share one handshake: an NB=4 instance that takes the upper
// 128 bits of the stimulus, and an NB=8 instance that takes all 256 bits.
// A queue model holds the expected permuted states. The byte permutation is
// computed from the row/column rule on byte arrays. A negedge compare process
// checks both instances against the model on every cycle.
// ----------------------------------------------------------------------------
module tb_shift_rows_pipe;

    localparam logic [127:0] VEC_LO  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FWD4_LIT = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] INV4_LIT = 128'h000d0a0704010e0b0805020f0c090603;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [255:0] in_data;
    logic [3:0]   in_tag;

    logic         in_ready4, out_valid4;
    logic [127:0] out_data4;
    logic [3:0]   out_tag4;
    logic [1:0]   occ4;

    logic         in_ready8, out_valid8;
    logic [255:0] out_data8;
    logic [3:0]   out_tag8;
    logic [1:0]   occ8;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data[255:128]), .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_tag(out_tag4), .occupancy(occ4)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_tag(out_tag8), .occupancy(occ8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Left-aligned state: byte k = 4c+r is d[255-8k -: 8]. The result uses the
    // same layout, with unused low bytes set to zero.
    function automatic logic [255:0] model_perm(input logic [255:0] d, input int nb, input bit inv);
        logic [7:0]   b [4][8];
        logic [255:0] res;
        int           s [4];
        int           src;
        res = '0;
        if (nb == 8) s = '{0, 1, 3, 4};
        else         s = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = d[255 - 8*(4*c + r) -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - s[r] + nb) % nb : (c + s[r]) % nb;
                res[255 - 8*(4*c + r) -: 8] = b[r][src];
            end
        return res;
    endfunction

    function automatic logic [7:0] get_byte(input logic [255:0] d, input int r, input int c);
        return d[255 - 8*(4*c + r) -: 8];
    endfunction

    typedef struct {
        logic [127:0] d4;
        logic [255:0] d8;
        logic [3:0]   tag;
    } exp_t;

    exp_t         q[$];
    logic [127:0] last_d4;
    logic [255:0] last_d8;
    logic [3:0]   last_tag;
    bit           model_live = 1'b0;

    always @(posedge clk) begin
        bit           push, pop;
        exp_t         e;
        logic [255:0] t;
        if (!rst_n) begin
            q.delete();
            last_d4    = '0;
            last_d8    = '0;
            last_tag   = '0;
            model_live = 1'b1;
        end else if (model_live) begin
            push = in_valid && (q.size() != 2);
            pop  = (q.size() != 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                t     = model_perm({in_data[255:128], 128'h0}, 4, in_inv);
                e.d4  = t[255:128];
                e.d8  = model_perm(in_data, 8, in_inv);
                e.tag = in_tag;
                q.push_back(e);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit exp_ready;
        if (model_live) begin
            exp_ready = rst_n && (q.size() != 2);
            if (q.size() > 0) begin
                last_d4  = q[0].d4;
                last_d8  = q[0].d8;
                last_tag = q[0].tag;
            end
            check("in_ready4",  in_ready4,  exp_ready);
            check("in_ready8",  in_ready8,  exp_ready);
            check("out_valid4", out_valid4, q.size() != 0);
            check("out_valid8", out_valid8, q.size() != 0);
            check("occupancy4", occ4, q.size());
            check("occupancy8", occ8, q.size());
            check("out_data4",  out_data4, last_d4);
            check("out_data8",  out_data8, last_d8);
            check("out_tag4",   out_tag4,  last_tag);
            check("out_tag8",   out_tag8,  last_tag);
        end
    end

    // Records the tags the consumer actually takes.
    logic [3:0] popped_tags[$];
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready) popped_tags.push_back(out_tag4);
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [255:0] d, input bit inv, input logic [3:0] tag);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_tag   = tag;
        for (int i = 0; i < 100 && !done; i++) begin
            #2;
            done = in_ready4;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: tag %0d accepted=0 required=1 within 100 cycles", tag);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [255:0] vec;
        logic [255:0] tmp;
        logic [255:0] fwd8;
        bit           stalled;

        vec       = {VEC_LO, 128'h101112131415161718191a1b1c1d1e1f};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_out_data8", out_data8, 256'h0);
        check("reset_in_ready",  in_ready4, 1'b0);
        rst_n = 1'b1;
        tick();

        // Pin the model to the hand-computed vectors.
        tmp = model_perm(vec, 4, 1'b0);
        check("pin_fwd4", tmp[255:128], FWD4_LIT);
        tmp = model_perm(vec, 4, 1'b1);
        check("pin_inv4", tmp[255:128], INV4_LIT);
        tmp = model_perm(model_perm(vec, 8, 1'b0), 8, 1'b1);
        check("pin_round8", tmp, vec);

        // Forward NB=4 vector and NB=8 byte spot checks, one cycle after the push.
        send(vec, 1'b0, 4'd1);
        check("t1_valid", out_valid4, 1'b1);
        check("t1_fwd4",  out_data4,  FWD4_LIT);
        check("t1_tag",   out_tag4,   4'd1);
        check("t3_b20",   get_byte(out_data8, 2, 0), 8'h0e);
        check("t3_b30",   get_byte(out_data8, 3, 0), 8'h13);
        check("t3_b17",   get_byte(out_data8, 1, 7), 8'h01);
        check("t3_b05",   get_byte(out_data8, 0, 5), 8'h14);
        fwd8 = out_data8;

        // Inverse NB=4 vector, then the two round trips.
        send(vec, 1'b1, 4'd2);
        check("t2_inv4", out_data4, INV4_LIT);
        send(fwd8, 1'b1, 4'd3);
        check("t3_round8", out_data8, vec);
        send({INV4_LIT, 128'h0}, 1'b0, 4'd4);
        check("t2_round4", out_data4, VEC_LO);
        tick();

        // Stalled consumer: fill the buffer, hold a third push, then drain.
        out_ready = 1'b0;
        popped_tags.delete();
        send(rand256(), 1'b0, 4'd1);
        check("t4_occ1", occ4, 2'd1);
        send(rand256(), 1'b1, 4'd2);
        check("t4_occ2", occ4, 2'd2);
        check("t4_in_ready_low", in_ready4, 1'b0);
        tmp      = rand256();
        in_valid = 1'b1;
        in_data  = tmp;
        in_inv   = 1'b0;
        in_tag   = 4'd3;
        repeat (3) tick();
        check("t4_still_full", occ4, 2'd2);
        out_ready = 1'b1;
        send(tmp, 1'b0, 4'd3);
        repeat (4) tick();
        check("t4_pop_count", popped_tags.size(), 3);
        if (popped_tags.size() == 3) begin
            check("t4_order0", popped_tags[0], 4'd1);
            check("t4_order1", popped_tags[1], 4'd2);
            check("t4_order2", popped_tags[2], 4'd3);
        end

        // Back-to-back stream with alternating direction.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = rand256();
            in_inv   = i[0];
            in_tag   = 4'(i);
            #2;
            check("t5_ready", in_ready4, 1'b1);
            if (i > 0) check("t5_occ", occ4, 2'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tick();

        // Reset while the buffer is full, with a push pending.
        out_ready = 1'b0;
        send(rand256(), 1'b0, 4'd5);
        send(rand256(), 1'b1, 4'd6);
        check("t6_full", occ4, 2'd2);
        in_valid = 1'b1;
        in_data  = rand256();
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("t6_occ",   occ4,       2'd0);
        check("t6_valid", out_valid4, 1'b0);
        check("t6_data4", out_data4,  128'h0);
        check("t6_data8", out_data8,  256'h0);
        #2;
        check("t6_ready", in_ready4, 1'b1);
        tick();

        // Random traffic with occasional resets. A stalled request is held stable.
        stalled = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand256();
                in_inv   = 1'($urandom());
                in_tag   = 4'($urandom());
            end
            out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 79) != 0);
            #2;
            stalled = in_valid && !in_ready4;
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
